// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : op codes, default latencies and FSM encoding for md_unit
// Optional feature macro: MD_MADD_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Operations that occupy the unit for a busy period.
  function automatic logic md_is_multi(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU:                  r = 1'b1;
`endif
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_calc.sv
// ============================================================================
// md_calc : combinational 64-bit multiply / divide / accumulate datapath
// Optional feature macro: MD_MADD_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [63:0] hilo_i,
  output logic [63:0] res_o,
  output logic        we_o
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign sprod = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign uprod = {32'd0, rs_i} * {32'd0, rt_i};

  // Signed divide built on magnitudes: avoids a native signed divide and makes
  // 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
  assign rs_mag = rs_i[31] ? (32'd0 - rs_i) : rs_i;
  assign rt_mag = rt_i[31] ? (32'd0 - rt_i) : rt_i;
  assign mag_q  = (rt_mag == 32'd0) ? 32'd0 : rs_mag / rt_mag;
  assign mag_r  = (rt_mag == 32'd0) ? 32'd0 : rs_mag % rt_mag;
  assign sq     = (rs_i[31] ^ rt_i[31]) ? (32'd0 - mag_q) : mag_q;
  assign sr     = rs_i[31] ? (32'd0 - mag_r) : mag_r;
  assign uq     = (rt_i == 32'd0) ? 32'd0 : rs_i / rt_i;
  assign ur     = (rt_i == 32'd0) ? 32'd0 : rs_i % rt_i;

  always_comb begin
    res_o = 64'd0;
    we_o  = 1'b0;
    case (op_i)
      MD_MULT:  begin res_o = sprod;    we_o = 1'b1; end
      MD_MULTU: begin res_o = uprod;    we_o = 1'b1; end
      MD_DIV:   begin res_o = {sr, sq}; we_o = (rt_i != 32'd0); end
      MD_DIVU:  begin res_o = {ur, uq}; we_o = (rt_i != 32'd0); end
`ifdef MD_MADD_EN
      MD_MADD:  begin res_o = hilo_i + sprod; we_o = 1'b1; end
      MD_MADDU: begin res_o = hilo_i + uprod; we_o = 1'b1; end
`endif
      default:  begin res_o = 64'd0;    we_o = 1'b0; end
    endcase
  end

`ifndef MD_MADD_EN
  logic unused_hilo;
  assign unused_hilo = ^hilo_i;
`endif

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// md_unit : multi-cycle MIPS multiply/divide unit with HI/LO and stall logic
// Optional feature macro: MD_MADD_EN (madd/maddu accumulate).  Revision: 1.0
// ============================================================================
`default_nettype none

module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [63:0] pend_q;
  logic        pend_we_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] calc_res;
  logic        calc_we;
  logic        ex_multi;

  md_calc u_calc (
    .op_i   (md_op),
    .rs_i   (rs_val),
    .rt_i   (rt_val),
    .hilo_i ({hi_q, lo_q}),
    .res_o  (calc_res),
    .we_o   (calc_we)
  );

  assign ex_multi = start & md_is_multi(md_op);

  // The result is computed at issue; HI/LO cannot change while RUN, so an
  // accumulate sees the same {hi,lo} it would at commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_we_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_multi) begin
            pend_q    <= calc_res;
            pend_we_q <= calc_we;
            cnt_q     <= md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end else if (start && (md_op == MD_MTHI)) begin
            hi_q <= rs_val;
          end else if (start && (md_op == MD_MTLO)) begin
            lo_q <= rs_val;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (pend_we_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = id_uses_md & (busy_q | ex_multi);

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit : directed vector bench for md_unit
// Optional feature macro: MD_MADD_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        id_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  vec_t vecs [14];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .md_op      (md_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .id_uses_md (id_uses_md),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at cycle T, then watch busy, the hold of HI/LO and the commit.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ncyc,
                        input string name);
    int bc;
    @(negedge clk);
    md_op = op; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    bc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (!busy) break;
      bc++;
      if (i == ncyc) begin
        check({name, " hold_hi"}, hi, m_hi);
        check({name, " hold_lo"}, lo, m_lo);
      end
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 32'(bc), 32'(ncyc));
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    int cnt;
    n_cmp = 0; n_fail = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    rst_n = 1'b0; start = 1'b0; md_op = MD_NONE;
    rs_val = 32'd0; rt_val = 32'd0; id_uses_md = 1'b0;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{MD_DIVU,  32'd10,       32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[6]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{MD_MULT,  32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
    vecs[8]  = '{MD_MTHI,  32'h0000ABCD, 32'd0,        32'h0000ABCD, 32'h23456780, 0};
    vecs[9]  = '{MD_MTLO,  32'h00001234, 32'd0,        32'h0000ABCD, 32'h00001234, 0};
    vecs[10] = '{MD_NONE,  32'hDEADBEEF, 32'd3,        32'h0000ABCD, 32'h00001234, 0};
    vecs[11] = '{4'd15,    32'hDEADBEEF, 32'd3,        32'h0000ABCD, 32'h00001234, 0};
    vecs[12] = '{MD_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 10};
    vecs[13] = '{MD_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++)
      run_op(vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].ehi, vecs[v].elo, vecs[v].cyc,
             $sformatf("vec%0d", v));

    // Stall: combinational in cycle T, then held by busy through T+5.
    @(negedge clk);
    id_uses_md = 1'b1; md_op = MD_MULT; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    #1 check("stall cycle T", 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      #1 if (stall) cnt++;
      @(negedge clk);
    end
    check("stall T+1..T+5", 32'(cnt), 32'd5);
    #1 check("stall T+6", 32'(stall), 32'd0);
    check("stall mult lo", lo, 32'd42);
    id_uses_md = 1'b0;

    // Start while busy is ignored; stall stays low without an ID-stage user.
    @(negedge clk);
    md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    md_op = MD_MTLO; rs_val = 32'h5555; start = 1'b1;
    #1 check("stall no id user", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("ignored-start busy end", 32'(busy), 32'd0);
    check("ignored-start lo", lo, 32'd12);
    check("ignored-start hi", hi, 32'd0);

    // Reset during a divide discards the pending result.
    @(negedge clk);
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy || hi != 32'd0 || lo != 32'd0) cnt++;
    end
    check("no late commit", 32'(cnt), 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    run_op(MD_MTHI, 32'd0, 32'd0, 32'd0, 32'd0, 0, "madd pre hi");
    run_op(MD_MTLO, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0, "madd pre lo");
`ifdef MD_MADD_EN
    run_op(MD_MADD, 32'd1, 32'd1, 32'd1, 32'd0, 5, "madd");
`else
    run_op(MD_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, "madd");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
